// File: rtl/conv_layer_engine.sv
// K x K window MAC engine over N_CH output channels: bias add, optional ReLU, saturation,
// and an output FIFO towards the next layer. Weights and biases are run-time loadable.
module conv_layer_engine #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned W_W   = 9,
  parameter int unsigned ACC_W = 18,
  parameter int unsigned K     = 3,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         relu_en,
  input  logic                                         strt,
  input  logic [K*K*IN_W-1:0]                          din,
  output logic                                         win_ack,
  output logic                                         busy,
  input  logic                                         w_wr,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   w_ch,
  input  logic [$clog2(K*K+1)-1:0]                     w_idx,
  input  logic [W_W-1:0]                               w_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [N_CH*ACC_W-1:0]                        out_data,
  output logic [$clog2(DEPTH+1)-1:0]                   fifo_cnt
);

  localparam int unsigned NPix = K * K;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RowW = (K > 1) ? $clog2(K) : 1;
  // Never narrower than a full-scale window sum, so narrow ACC_W still saturates correctly.
  localparam int unsigned MinW = IN_W + W_W + $clog2(NPix) + 2;
  localparam int unsigned SumW = (ACC_W + 4 > MinW) ? ACC_W + 4 : MinW;

  localparam logic signed [SumW-1:0] SatMax = {{(SumW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = {{(SumW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StWrite} state_e;

  state_e                 state_q, state_d;
  logic [RowW-1:0]        row_q, row_d;
  logic signed [SumW-1:0] acc_q [N_CH];
  logic signed [SumW-1:0] acc_d [N_CH];
  logic signed [SumW-1:0] row_sum [N_CH];
  logic [W_W-1:0]         w_q [N_CH][NPix];
  logic [W_W-1:0]         b_q [N_CH];

  logic [N_CH*ACC_W-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [N_CH*ACC_W-1:0]  res_word;
  logic signed [SumW-1:0] tot;
  logic                   push, pop, full;
  int unsigned            p;

  assign full      = (cnt_q == CntW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != StIdle);
  assign out_valid = (cnt_q != '0);
  assign fifo_cnt  = cnt_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        b_q[c] <= '0;
        for (int i = 0; i < NPix; i++) w_q[c][i] <= '0;
      end
    end else if (w_wr && (state_q == StIdle) && !flush && (32'(w_ch) < N_CH)) begin
      if (32'(w_idx) < NPix)       w_q[w_ch][w_idx] <= w_data;
      else if (32'(w_idx) == NPix) b_q[w_ch] <= w_data;
    end
  end

  always_comb begin
    p = 0;
    for (int c = 0; c < N_CH; c++) begin
      row_sum[c] = '0;
      for (int j = 0; j < K; j++) begin
        p = 32'(row_q) * K + j;
        row_sum[c] = row_sum[c]
                   + $signed({{(SumW-IN_W){1'b0}}, din[p*IN_W +: IN_W]})
                   * $signed({{(SumW-W_W){w_q[c][p][W_W-1]}}, w_q[c][p]});
      end
    end
  end

  always_comb begin
    res_word = '0;
    tot      = '0;
    for (int c = 0; c < N_CH; c++) begin
      tot = acc_q[c] + $signed({{(SumW-W_W){b_q[c][W_W-1]}}, b_q[c]});
      if (relu_en && tot[SumW-1]) res_word[c*ACC_W +: ACC_W] = '0;
      else if (tot > SatMax)      res_word[c*ACC_W +: ACC_W] = SatMax[ACC_W-1:0];
      else if (tot < SatMin)      res_word[c*ACC_W +: ACC_W] = SatMin[ACC_W-1:0];
      else                        res_word[c*ACC_W +: ACC_W] = tot[ACC_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    push    = 1'b0;
    win_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strt && !full) begin
          state_d = StMac;
          row_d   = '0;
          for (int c = 0; c < N_CH; c++) acc_d[c] = '0;
        end
      end
      StMac: begin
        for (int c = 0; c < N_CH; c++) acc_d[c] = acc_q[c] + row_sum[c];
        if (row_q == RowW'(K - 1)) state_d = StWrite;
        else                       row_d   = row_q + 1'b1;
      end
      StWrite: begin
        push    = 1'b1;
        win_ack = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      row_d   = '0;
      push    = 1'b0;
      win_ack = 1'b0;
      for (int c = 0; c < N_CH; c++) acc_d[c] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Payload needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_word;
  end

  // strt is held off while full, so a push can never find the FIFO full.
  push_not_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine: a default instance plus an ACC_W=8 instance share
// all inputs; a queue scoreboard fed by a behavioural model checks every popped word.
module tb_conv_layer_engine;

  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst, flush, relu_en, strt, w_wr, out_ready;
  logic [17:0] din;
  logic [0:0]  w_ch;
  logic [3:0]  w_idx;
  logic [8:0]  w_data;
  logic        win_ack, busy, out_valid;
  logic [35:0] out_data;
  logic [2:0]  fifo_cnt;
  logic        win_ack8, busy8, out_valid8;
  logic [15:0] out_data8;
  logic [2:0]  fifo_cnt8;

  int n_err = 0;
  int n_chk = 0;
  int w_m [2][9];
  int b_m [2];
  logic [35:0] exp_q [$];
  logic [15:0] exp8_q [$];

  always #5 clk = ~clk;

  conv_layer_engine u_dut (
    .clk(clk), .rst(rst), .flush(flush), .relu_en(relu_en), .strt(strt), .din(din),
    .win_ack(win_ack), .busy(busy), .w_wr(w_wr), .w_ch(w_ch), .w_idx(w_idx),
    .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_cnt(fifo_cnt)
  );

  conv_layer_engine #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush), .relu_en(relu_en), .strt(strt), .din(din),
    .win_ack(win_ack8), .busy(busy8), .w_wr(w_wr), .w_ch(w_ch), .w_idx(w_idx),
    .w_data(w_data), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .fifo_cnt(fifo_cnt8)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int accw, input logic [17:0] d, input logic relu);
    logic [63:0] r, m;
    longint s, mx, mn;
    r  = '0;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -mx - 1;
    m  = (64'd1 << accw) - 64'd1;
    for (int c = 0; c < 2; c++) begin
      s = b_m[c];
      for (int i = 0; i < 9; i++) s += longint'(d[i*2 +: 2]) * w_m[c][i];
      if (s > mx) s = mx;
      if (s < mn) s = mn;
      if (relu && s < 0) s = 0;
      r = r | ((64'(s) & m) << (c * accw));
    end
    return r;
  endfunction

  task automatic push_exp(input logic [17:0] d);
    logic [63:0] t;
    t = model(18, d, relu_en);
    exp_q.push_back(t[35:0]);
    t = model(8, d, relu_en);
    exp8_q.push_back(t[15:0]);
  endtask

  // Pops are judged before the edge that performs them.
  task automatic tick();
    logic [35:0] e;
    logic [15:0] e8;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e);
      end
    end
    if (out_valid8 && out_ready) begin
      if (exp8_q.size() == 0) chk("sb8_underflow", exp8_q.size(), 1);
      else begin
        e8 = exp8_q.pop_front();
        chk("sb8_data", out_data8, e8);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int ch, input int idx, input int data, input bit upd);
    w_ch = 1'(ch); w_idx = 4'(idx); w_data = 9'(data); w_wr = 1'b1;
    tick();
    w_wr = 1'b0;
    if (upd && idx < 9) w_m[ch][idx] = data;
    else if (upd && idx == 9) b_m[ch] = data;
  endtask

  task automatic start_window(input logic [17:0] d);
    din = d; strt = 1'b1;
    push_exp(d);
    tick();
    strt = 1'b0;
  endtask

  task automatic finish_window(input int n0, input bit chk_valid);
    int n;
    n = n0;
    while (!win_ack && n < 20) begin tick(); n++; end
    chk("ack_cycle", n, K + 1);
    chk("ack8", win_ack8, 1);
    tick();
    if (chk_valid) chk("valid_cycle", out_valid, 1);
  endtask

  task automatic run_window(input logic [17:0] d, input bit chk_valid);
    start_window(d);
    finish_window(1, chk_valid);
  endtask

  task automatic set_ch(input int ch, input int w, input int b);
    for (int i = 0; i < 9; i++) wr_w(ch, i, w, 1'b1);
    wr_w(ch, 9, b, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [17:0] d;
    rst = 1'b1; flush = 1'b0; relu_en = 1'b0; strt = 1'b0; w_wr = 1'b0; out_ready = 1'b1;
    din = '0; w_ch = '0; w_idx = '0; w_data = '0;
    for (int c = 0; c < 2; c++) begin
      b_m[c] = 0;
      for (int i = 0; i < 9; i++) w_m[c][i] = 0;
    end
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ack", win_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // 1: unit weights, din all 3
    set_ch(0, 1, 0);
    set_ch(1, 1, 0);
    start_window(18'h3FFFF);
    chk("busy_mac", busy, 1);
    finish_window(1, 1'b1);
    chk("t1_ch0", $signed(out_data[17:0]), 27);
    chk("t1_ch1", $signed(out_data[35:18]), 27);
    chk("t1_8_ch0", $signed(out_data8[7:0]), 27);

    // 2: negative weights and bias, din all 1, with and without ReLU
    set_ch(0, -256, -256);
    run_window(18'h15555, 1'b1);
    chk("t2_ch0", $signed(out_data[17:0]), -2560);
    chk("t2_ch1", $signed(out_data[35:18]), 9);
    chk("t2_8_ch0", $signed(out_data8[7:0]), -128);
    relu_en = 1'b1;
    run_window(18'h15555, 1'b1);
    chk("t2_relu_ch0", $signed(out_data[17:0]), 0);
    tick();
    relu_en = 1'b0;

    // 3: saturation on the ACC_W=8 instance
    set_ch(0, 255, 0);
    run_window(18'h3FFFF, 1'b1);
    chk("t3_8_pos", $signed(out_data8[7:0]), 127);
    chk("t3_wide_pos", $signed(out_data[17:0]), 6885);
    set_ch(0, -256, 0);
    run_window(18'h3FFFF, 1'b1);
    chk("t3_8_neg", $signed(out_data8[7:0]), -128);
    chk("t3_wide_neg", $signed(out_data[17:0]), -6912);
    tick();

    // 4: backpressure, fifth window held off until the FIFO drains
    set_ch(1, 7, -3);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) run_window(18'($urandom), i == 0);
    chk("t4_full_cnt", fifo_cnt, 4);
    d = 18'($urandom);
    din = d; strt = 1'b1;
    push_exp(d);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_held_busy", busy, 0);
      chk("t4_held_ack", win_ack, 0);
    end
    chk("t4_held_cnt", fifo_cnt, 4);
    out_ready = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    strt = 1'b0;
    chk("t4_fifth_accepted", busy, 1);
    finish_window(1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin tick(); n++; end
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_cnt0", fifo_cnt, 0);

    // 5: flush during MAC cycle 2
    out_ready = 1'b0;
    run_window(18'h2D2D2, 1'b1);
    chk("t5_cnt1", fifo_cnt, 1);
    din = 18'h0F0F0; strt = 1'b1;
    tick();
    strt = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_cnt", fifo_cnt, 0);
    chk("t5_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_ack", win_ack, 0);
      tick();
    end
    exp_q.delete();
    exp8_q.delete();
    out_ready = 1'b1;
    run_window(18'h1B6DB, 1'b1);
    tick();

    // 6: weight write during MAC and out-of-range index are ignored
    start_window(18'h3FFFF);
    w_ch = 1'b1; w_idx = 4'd0; w_data = 9'd100; w_wr = 1'b1;
    tick();
    w_wr = 1'b0;
    finish_window(2, 1'b1);
    wr_w(0, 12, 77, 1'b0);
    run_window(18'h3FFFF, 1'b1);
    tick();
    chk("t6_sb_empty", exp_q.size(), 0);

    // rst mid-MAC
    out_ready = 1'b0;
    run_window(18'h3FFFF, 1'b1);
    din = 18'h3FFFF; strt = 1'b1;
    tick();
    strt = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ack", win_ack, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_cnt", fifo_cnt, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_data8", out_data8, 0);
    #1 rst = 1'b0;
    exp_q.delete();
    exp8_q.delete();
    for (int c = 0; c < 2; c++) begin
      b_m[c] = 0;
      for (int i = 0; i < 9; i++) w_m[c][i] = 0;
    end
    tick();
    out_ready = 1'b1;
    run_window(18'h3FFFF, 1'b1);
    chk("t6_zero_weights", out_data, 0);
    tick();
    chk("end_sb_empty", exp_q.size(), 0);
    chk("end_sb8_empty", exp8_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
